// File: rtl/crossbar_switch_allocator.sv
// Wormhole switch allocator for a 5-port crossbar: per-output round-robin lock FSMs with a lock watchdog.
// Arbitration takes 1 cycle; once an output is locked, grants follow req_i & out_ready_i combinationally.
module crossbar_switch_allocator #(
  parameter int NPORTS       = 5,
  parameter int SELW         = 3,
  parameter int LOCK_TIMEOUT = 255,
  parameter int TOW          = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NPORTS-1:0]      req_i,
  input  logic [NPORTS*SELW-1:0] dest_i,
  input  logic [NPORTS-1:0]      tail_i,
  input  logic [NPORTS-1:0]      out_ready_i,
  output logic [NPORTS-1:0]      gnt_o,
  output logic [NPORTS*SELW-1:0] sel_demux_o,
  output logic [NPORTS*SELW-1:0] sel_mux_o,
  output logic [NPORTS-1:0]      out_valid_o,
  output logic                   bad_dest_o,
  output logic                   timeout_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state  [NPORTS];
  logic [SELW-1:0] owner  [NPORTS];
  logic [SELW-1:0] ptr    [NPORTS];
  logic [TOW-1:0]  wd_cnt [NPORTS];

  logic [NPORTS-1:0] busy;
  logic [NPORTS-1:0] xfer;
  logic [NPORTS-1:0] expire;
  logic [NPORTS-1:0] found;
  logic [NPORTS-1:0] cand   [NPORTS];
  logic [SELW-1:0]   winner [NPORTS];

  function automatic logic [SELW-1:0] succ(input logic [SELW-1:0] p);
    return (p == SELW'(NPORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Steering and grants depend only on registered lock state plus live req/ready.
  always_comb begin
    busy        = '0;
    xfer        = '0;
    gnt_o       = '0;
    out_valid_o = '0;
    sel_mux_o   = '0;
    sel_demux_o = '0;
    for (int q = 0; q < NPORTS; q++) begin
      if (state[q] == LOCKED) begin
        busy[owner[q]]                             = 1'b1;
        xfer[q]                                    = req_i[owner[q]] & out_ready_i[q];
        gnt_o[owner[q]]                            = xfer[q];
        out_valid_o[q]                             = xfer[q];
        sel_mux_o[q*SELW +: SELW]                  = owner[q];
        sel_demux_o[int'(owner[q])*SELW +: SELW]   = SELW'(q);
      end
    end
  end

  always_comb begin
    bad_dest_o = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (req_i[p] && (dest_i[p*SELW +: SELW] >= SELW'(NPORTS))) bad_dest_o = 1'b1;
    end
  end

  // Scanning 2*NPORTS positions from ptr covers the wrap without a rotator.
  always_comb begin
    for (int q = 0; q < NPORTS; q++) begin
      found[q]  = 1'b0;
      winner[q] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        cand[q][p] = req_i[p] && (dest_i[p*SELW +: SELW] == SELW'(q)) && !busy[p];
      end
      for (int k = 0; k < 2*NPORTS; k++) begin
        if (!found[q] && (k >= int'(ptr[q])) && cand[q][k % NPORTS]) begin
          found[q]  = 1'b1;
          winner[q] = SELW'(k % NPORTS);
        end
      end
    end
  end

  always_comb begin
    for (int q = 0; q < NPORTS; q++) begin
      expire[q] = (LOCK_TIMEOUT != 0) && (state[q] == LOCKED) && !xfer[q] &&
                  (wd_cnt[q] + 1'b1 == TOW'(LOCK_TIMEOUT));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_o <= 1'b0;
      for (int q = 0; q < NPORTS; q++) begin
        state[q]  <= IDLE;
        owner[q]  <= '0;
        ptr[q]    <= '0;
        wd_cnt[q] <= '0;
      end
    end else begin
      timeout_o <= |expire;
      for (int q = 0; q < NPORTS; q++) begin
        if (state[q] == IDLE) begin
          if (found[q]) begin
            state[q]  <= LOCKED;
            owner[q]  <= winner[q];
            wd_cnt[q] <= '0;
          end
        end else if (xfer[q] && tail_i[owner[q]]) begin
          state[q]  <= IDLE;
          ptr[q]    <= succ(owner[q]);
          wd_cnt[q] <= '0;
        end else if (expire[q]) begin
          state[q]  <= IDLE;
          ptr[q]    <= succ(owner[q]);
          wd_cnt[q] <= '0;
        end else if (xfer[q]) begin
          wd_cnt[q] <= '0;
        end else if (wd_cnt[q] != '1) begin
          wd_cnt[q] <= wd_cnt[q] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_switch_allocator.sv
// Bench for crossbar_switch_allocator: directed vector table, hand-written corner sequences, random traffic vs a packet-level model.
module tb_crossbar_switch_allocator;
  localparam int LT = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req, tail, ready;
  logic [14:0] dest;
  logic [4:0]  gnt, valid;
  logic [14:0] sdemux, smux;
  logic        bad, tout;

  always #5 clk = ~clk;

  crossbar_switch_allocator #(.NPORTS(5), .SELW(3), .LOCK_TIMEOUT(LT), .TOW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .dest_i(dest), .tail_i(tail),
    .out_ready_i(ready), .gnt_o(gnt), .sel_demux_o(sdemux), .sel_mux_o(smux),
    .out_valid_o(valid), .bad_dest_o(bad), .timeout_o(tout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Packet-level model: owner -1 means the output is free.
  int m_owner[5];
  int m_ptr[5];
  int m_stall[5];
  bit m_tout;

  function automatic void m_reset();
    for (int q = 0; q < 5; q++) begin
      m_owner[q] = -1; m_ptr[q] = 0; m_stall[q] = 0;
    end
    m_tout = 1'b0;
  endfunction

  function automatic int dst(int p);
    return int'(dest[3*p +: 3]);
  endfunction

  function automatic void m_outputs(output logic [4:0] g, output logic [4:0] v,
                                    output logic [14:0] mx, output logic [14:0] dm, output logic b);
    g = '0; v = '0; mx = '0; dm = '0; b = 1'b0;
    for (int q = 0; q < 5; q++) begin
      if (m_owner[q] >= 0) begin
        mx[3*q +: 3]          = 3'(m_owner[q]);
        dm[3*m_owner[q] +: 3] = 3'(q);
        if (req[m_owner[q]] && ready[q]) begin
          g[m_owner[q]] = 1'b1;
          v[q]          = 1'b1;
        end
      end
    end
    for (int p = 0; p < 5; p++) if (req[p] && dst(p) > 4) b = 1'b1;
  endfunction

  function automatic void m_step();
    bit busy[5];
    bit got;
    int o, p;
    for (int i = 0; i < 5; i++) busy[i] = 1'b0;
    for (int q = 0; q < 5; q++) if (m_owner[q] >= 0) busy[m_owner[q]] = 1'b1;
    m_tout = 1'b0;
    for (int q = 0; q < 5; q++) begin
      if (m_owner[q] >= 0) begin
        o = m_owner[q];
        if (req[o] && ready[q]) begin
          m_stall[q] = 0;
          if (tail[o]) begin
            m_owner[q] = -1; m_ptr[q] = (o + 1) % 5;
          end
        end else begin
          if (m_stall[q] < 255) m_stall[q]++;
          if (m_stall[q] == LT) begin
            m_owner[q] = -1; m_ptr[q] = (o + 1) % 5; m_stall[q] = 0; m_tout = 1'b1;
          end
        end
      end else begin
        got = 1'b0;
        for (int k = 0; k < 5; k++) begin
          p = (m_ptr[q] + k) % 5;
          if (!got && req[p] && dst(p) == q && !busy[p]) begin
            got = 1'b1; m_owner[q] = p; m_stall[q] = 0;
          end
        end
      end
    end
  endfunction

  logic [4:0]  obs_gnt, obs_valid;
  logic [14:0] obs_smux, obs_sdemux;
  logic        obs_bad, obs_tout;

  // Starts just after a rising edge; checks at the falling edge; ends just after the next rising edge.
  task automatic step(input logic [4:0] r, input logic [14:0] d, input logic [4:0] t,
                      input logic [4:0] rd, input string tag);
    logic [4:0]  eg, ev;
    logic [14:0] emx, edm;
    logic        eb;
    req = r; dest = d; tail = t; ready = rd;
    @(negedge clk);
    m_outputs(eg, ev, emx, edm, eb);
    obs_gnt = gnt; obs_valid = valid; obs_smux = smux; obs_sdemux = sdemux;
    obs_bad = bad; obs_tout = tout;
    chk({tag, "_gnt"},   32'(gnt),    32'(eg));
    chk({tag, "_valid"}, 32'(valid),  32'(ev));
    chk({tag, "_mux"},   32'(smux),   32'(emx));
    chk({tag, "_demux"}, 32'(sdemux), 32'(edm));
    chk({tag, "_bad"},   32'(bad),    32'(eb));
    chk({tag, "_tout"},  32'(tout),   32'(m_tout));
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct {
    logic [4:0]  req;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [4:0]  gnt;
    logic [4:0]  valid;
    logic [14:0] mux;
    logic [14:0] demux;
    logic        bad;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [4:0]  r;
    logic [14:0] d;
    rst_n = 1'b0; req = '0; dest = '0; tail = '0; ready = '0;
    m_reset();

    // N->L single packet of 3 flits
    tbl.push_back('{5'h01, 15'h0004, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    tbl.push_back('{5'h01, 15'h0004, 5'h00, 5'h1F, 5'h01, 5'h10, 15'h0000, 15'h0004, 1'b0});
    tbl.push_back('{5'h01, 15'h0004, 5'h00, 5'h1F, 5'h01, 5'h10, 15'h0000, 15'h0004, 1'b0});
    tbl.push_back('{5'h01, 15'h0004, 5'h01, 5'h1F, 5'h01, 5'h10, 15'h0000, 15'h0004, 1'b0});
    tbl.push_back('{5'h00, 15'h0004, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    // full permutation, single-flit packets
    tbl.push_back('{5'h1F, 15'h08D1, 5'h1F, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    tbl.push_back('{5'h1F, 15'h08D1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 15'h3444, 15'h08D1, 1'b0});
    tbl.push_back('{5'h00, 15'h08D1, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    // invalid destination on E
    tbl.push_back('{5'h08, 15'h0C00, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b1});
    tbl.push_back('{5'h08, 15'h0C00, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b1});
    tbl.push_back('{5'h00, 15'h0C00, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    // N, S, W contend for E with 2-flit packets
    tbl.push_back('{5'h07, 15'h00DB, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    tbl.push_back('{5'h07, 15'h00DB, 5'h00, 5'h1F, 5'h01, 5'h08, 15'h0000, 15'h0003, 1'b0});
    tbl.push_back('{5'h07, 15'h00DB, 5'h01, 5'h1F, 5'h01, 5'h08, 15'h0000, 15'h0003, 1'b0});
    tbl.push_back('{5'h06, 15'h00DB, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    tbl.push_back('{5'h06, 15'h00DB, 5'h00, 5'h1F, 5'h02, 5'h08, 15'h0200, 15'h0018, 1'b0});
    tbl.push_back('{5'h06, 15'h00DB, 5'h02, 5'h1F, 5'h02, 5'h08, 15'h0200, 15'h0018, 1'b0});
    tbl.push_back('{5'h04, 15'h00DB, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});
    tbl.push_back('{5'h04, 15'h00DB, 5'h00, 5'h1F, 5'h04, 5'h08, 15'h0400, 15'h00C0, 1'b0});
    tbl.push_back('{5'h04, 15'h00DB, 5'h04, 5'h1F, 5'h04, 5'h08, 15'h0400, 15'h00C0, 1'b0});
    tbl.push_back('{5'h00, 15'h00DB, 5'h00, 5'h1F, 5'h00, 5'h00, 15'h0000, 15'h0000, 1'b0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_mux", 32'(smux), 0);
    chk("rst_demux", 32'(sdemux), 0);
    chk("rst_bad", 32'(bad), 0);
    chk("rst_tout", 32'(tout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].dest, tbl[i].tail, tbl[i].ready, "tbl_model");
      chk($sformatf("tbl%0d_gnt", i),   32'(obs_gnt),    32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(obs_valid),  32'(tbl[i].valid));
      chk($sformatf("tbl%0d_mux", i),   32'(obs_smux),   32'(tbl[i].mux));
      chk($sformatf("tbl%0d_demux", i), 32'(obs_sdemux), 32'(tbl[i].demux));
      chk($sformatf("tbl%0d_bad", i),   32'(obs_bad),    32'(tbl[i].bad));
    end

    // W locked to N: downstream stall, resume, then owner goes silent until the watchdog fires
    step(5'h04, 15'h0000, 5'h00, 5'h1F, "t4_arb");
    step(5'h04, 15'h0000, 5'h00, 5'h1F, "t4_f1");
    chk("t4_f1_gnt", 32'(obs_gnt), 32'h04);
    for (int i = 0; i < 3; i++) begin
      step(5'h04, 15'h0000, 5'h00, 5'h1E, "t4_stall");
      chk("t4_stall_gnt", 32'(obs_gnt), 0);
      chk("t4_stall_mux", 32'(obs_smux), 32'h0002);
    end
    step(5'h04, 15'h0000, 5'h00, 5'h1F, "t4_resume");
    chk("t4_resume_gnt", 32'(obs_gnt), 32'h04);
    chk("t4_resume_mux", 32'(obs_smux), 32'h0002);
    for (int i = 0; i < LT; i++) step(5'h00, 15'h0000, 5'h00, 5'h1F, "t4_idle");
    chk("t4_pre_tout", 32'(obs_tout), 0);
    chk("t4_pre_mux", 32'(obs_smux), 32'h0002);
    step(5'h00, 15'h0000, 5'h00, 5'h1F, "t4_tout");
    chk("t4_tout", 32'(obs_tout), 1);
    chk("t4_tout_mux", 32'(obs_smux), 0);
    step(5'h00, 15'h0000, 5'h00, 5'h1F, "t4_after");
    chk("t4_after_tout", 32'(obs_tout), 0);

    // S->L packet interrupted by an asynchronous reset
    step(5'h02, 15'h0020, 5'h00, 5'h1F, "t6_arb");
    step(5'h02, 15'h0020, 5'h00, 5'h1F, "t6_f1");
    chk("t6_f1_gnt", 32'(obs_gnt), 32'h02);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 0);
    chk("t6_rst_valid", 32'(valid), 0);
    chk("t6_rst_mux", 32'(smux), 0);
    m_reset();
    req = '0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    req = 5'h02; dest = 15'h0020; tail = '0; ready = 5'h1F;
    @(negedge clk);
    chk("t6_arb_gnt", 32'(gnt), 0);
    @(posedge clk);
    m_step();
    #1;
    step(5'h02, 15'h0020, 5'h00, 5'h1F, "t6_g1");
    chk("t6_g1_gnt", 32'(obs_gnt), 32'h02);
    step(5'h02, 15'h0020, 5'h02, 5'h1F, "t6_tail");
    step(5'h00, 15'h0020, 5'h00, 5'h1F, "t6_end");

    // random traffic: sticky requests, occasional dest changes and invalid dests
    r = '0; d = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 5; p++) begin
        if ($urandom_range(0, 7) == 0) r[p] = ~r[p];
        if ($urandom_range(0, 3) == 0)
          d[3*p +: 3] = ($urandom_range(0, 15) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      end
      step(r, d, 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
